tx_link_sched: RTL and testbench

//  Link-level controller in front of the PCIE transmitter. Sequences the link

---
 rtl/tx_link_sched.sv | 199 +++++++++++++++++++
 tb/tb_tx_link_sched.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/tx_link_sched.sv
// Link-level transmit scheduler: walks the link through idle, COM training, active data and
// EIOS idle entry, round-robins three sources onto the transmitter and inserts periodic SKPs.
module tx_link_sched #(
    parameter int unsigned TS_LEN  = 16,
    parameter int unsigned BURST   = 4,
    parameter int unsigned SKP_INT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        link_en,
    input  logic        idle_req,
    input  logic        tx_rdy,
    input  logic [2:0]  req,
    input  logic [7:0]  data8,
    input  logic [15:0] data16,
    input  logic [31:0] data32,
    output logic [2:0]  gnt,
    output logic        enb,
    output logic        TxElecIdle,
    output logic        K,
    output logic [1:0]  dataS,
    output logic [31:0] dataOut,
    output logic        link_up
);

    localparam int unsigned TSW = $clog2(TS_LEN + 1);
    localparam int unsigned BW  = $clog2(BURST + 1);
    localparam int unsigned SW  = $clog2(SKP_INT + 1);

    localparam logic [TSW-1:0] TS_LAST = TSW'(TS_LEN - 1);
    localparam logic [BW-1:0]  B_LAST  = BW'(BURST - 1);
    localparam logic [SW-1:0]  SKP_MAX = SW'(SKP_INT);

    localparam logic [7:0] SYM_COM  = 8'hBC;
    localparam logic [7:0] SYM_SKP  = 8'h1C;
    localparam logic [7:0] SYM_PAD  = 8'hF7;
    localparam logic [7:0] SYM_EIOS = 8'h7C;

    typedef enum logic [1:0] {IDLE, TRAIN, ACTIVE, EIDLE_WAIT} state_t;

    state_t         state, stateNxt;
    logic           ownerVld, ownerVldNxt;
    logic [1:0]     owner, ownerNxt;
    logic [1:0]     rrPtr, rrPtrNxt;
    logic [TSW-1:0] tsCnt, tsCntNxt;
    logic [BW-1:0]  burstCnt, burstCntNxt;
    logic [SW-1:0]  skpCnt, skpCntNxt;
    logic           enbNxt, elecIdleNxt, kNxt;
    logic [1:0]     dataSNxt;
    logic [31:0]    dataOutNxt;

    logic           pickVld;
    logic [1:0]     pickIdx;
    logic [2:0]     cand;
    logic [31:0]    srcData;

    assign link_up = (state == ACTIVE);
    assign gnt     = (state == ACTIVE && ownerVld) ? (3'b001 << owner) : 3'b000;

    // First requester at or after rrPtr, wrapping modulo 3
    always_comb begin
        pickVld = 1'b0;
        pickIdx = '0;
        cand    = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            cand = {1'b0, rrPtr} + 3'(i);
            if (cand >= 3'd3) cand = cand - 3'd3;
            if (!pickVld && req[cand[1:0]]) begin
                pickVld = 1'b1;
                pickIdx = cand[1:0];
            end
        end
    end

    always_comb begin
        case (owner)
            2'd0:    srcData = {24'h0, data8};
            2'd1:    srcData = {16'h0, data16};
            default: srcData = data32;
        endcase
    end

    always_comb begin
        stateNxt    = state;
        ownerVldNxt = ownerVld;
        ownerNxt    = owner;
        rrPtrNxt    = rrPtr;
        tsCntNxt    = tsCnt;
        burstCntNxt = burstCnt;
        skpCntNxt   = skpCnt;
        enbNxt      = enb;
        elecIdleNxt = TxElecIdle;
        kNxt        = K;
        dataSNxt    = dataS;
        dataOutNxt  = dataOut;

        if (state != IDLE && !link_en) begin
            // Abort ignores tx_rdy; rrPtr survives so fairness carries across retraining
            stateNxt    = IDLE;
            ownerVldNxt = 1'b0;
            ownerNxt    = '0;
            tsCntNxt    = '0;
            burstCntNxt = '0;
            skpCntNxt   = '0;
            enbNxt      = 1'b0;
            elecIdleNxt = 1'b1;
            kNxt        = 1'b0;
            dataSNxt    = 2'b00;
            dataOutNxt  = '0;
        end else if (tx_rdy) begin
            case (state)
                IDLE: begin
                    if (link_en) begin
                        stateNxt    = TRAIN;
                        enbNxt      = 1'b1;
                        elecIdleNxt = 1'b0;
                        tsCntNxt    = '0;
                    end
                end
                TRAIN: begin
                    kNxt       = 1'b1;
                    dataSNxt   = 2'b00;
                    dataOutNxt = {24'h0, SYM_COM};
                    tsCntNxt   = tsCnt + 1'b1;
                    if (tsCnt == TS_LAST) stateNxt = ACTIVE;
                end
                ACTIVE: begin
                    kNxt     = 1'b1;
                    dataSNxt = 2'b00;
                    if (ownerVld && req[owner]) begin
                        kNxt        = 1'b0;
                        dataSNxt    = owner;
                        dataOutNxt  = srcData;
                        burstCntNxt = burstCnt + 1'b1;
                        if (skpCnt != SKP_MAX) skpCntNxt = skpCnt + 1'b1;
                        if (burstCnt == B_LAST) ownerVldNxt = 1'b0;
                    end else if (ownerVld) begin
                        ownerVldNxt = 1'b0;
                        dataOutNxt  = {24'h0, SYM_PAD};
                    end else if (idle_req) begin
                        dataOutNxt = {24'h0, SYM_EIOS};
                        stateNxt   = EIDLE_WAIT;
                    end else if (skpCnt >= SKP_MAX) begin
                        dataOutNxt = {24'h0, SYM_SKP};
                        skpCntNxt  = '0;
                    end else begin
                        dataOutNxt = {24'h0, SYM_PAD};
                        if (pickVld) begin
                            ownerVldNxt = 1'b1;
                            ownerNxt    = pickIdx;
                            burstCntNxt = '0;
                            rrPtrNxt    = (pickIdx == 2'd2) ? 2'd0 : pickIdx + 2'd1;
                        end
                    end
                end
                EIDLE_WAIT: begin
                    stateNxt    = IDLE;
                    elecIdleNxt = 1'b1;
                    enbNxt      = 1'b0;
                    kNxt        = 1'b0;
                    dataSNxt    = 2'b00;
                    dataOutNxt  = '0;
                end
                default: stateNxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            ownerVld   <= 1'b0;
            owner      <= '0;
            rrPtr      <= '0;
            tsCnt      <= '0;
            burstCnt   <= '0;
            skpCnt     <= '0;
            enb        <= 1'b0;
            TxElecIdle <= 1'b1;
            K          <= 1'b0;
            dataS      <= 2'b00;
            dataOut    <= '0;
        end else begin
            state      <= stateNxt;
            ownerVld   <= ownerVldNxt;
            owner      <= ownerNxt;
            rrPtr      <= rrPtrNxt;
            tsCnt      <= tsCntNxt;
            burstCnt   <= burstCntNxt;
            skpCnt     <= skpCntNxt;
            enb        <= enbNxt;
            TxElecIdle <= elecIdleNxt;
            K          <= kNxt;
            dataS      <= dataSNxt;
            dataOut    <= dataOutNxt;
        end
    end

endmodule

// File: tb/tb_tx_link_sched.sv
// Scoreboard bench for tx_link_sched: stimulus queues the expected symbol per cycle,
// a monitor compares after every clock edge.
module tb_tx_link_sched;

    localparam int unsigned TS   = 16;
    localparam int unsigned SKPI = 8;

    localparam logic [7:0] COM  = 8'hBC;
    localparam logic [7:0] SKP  = 8'h1C;
    localparam logic [7:0] PAD  = 8'hF7;
    localparam logic [7:0] EIOS = 8'h7C;

    logic        clk = 1'b0;
    logic        rst, link_en, idle_req, tx_rdy;
    logic [2:0]  req;
    logic [7:0]  data8;
    logic [15:0] data16;
    logic [31:0] data32;
    logic [2:0]  gnt;
    logic        enb, TxElecIdle, K, link_up;
    logic [1:0]  dataS;
    logic [31:0] dataOut;

    always #5 clk = ~clk;

    tx_link_sched #(.TS_LEN(TS), .BURST(4), .SKP_INT(SKPI)) dut (
        .clk(clk), .rst(rst), .link_en(link_en), .idle_req(idle_req), .tx_rdy(tx_rdy),
        .req(req), .data8(data8), .data16(data16), .data32(data32), .gnt(gnt),
        .enb(enb), .TxElecIdle(TxElecIdle), .K(K), .dataS(dataS), .dataOut(dataOut),
        .link_up(link_up)
    );

    typedef struct packed {
        logic        k;
        logic [1:0]  ds;
        logic [31:0] d;
        logic        ei;
        logic        en;
        logic        lu;
    } obs_t;

    obs_t expQ[$];
    obs_t cur;
    obs_t act;
    obs_t want;
    int   tests = 0;
    int   fails = 0;
    int   slotNo = 0;
    bit   monEn = 1'b0;

    // Monitor: one observation per clock while enabled
    always @(posedge clk) begin
        if (monEn) begin
            #1;
            act = '{k: K, ds: dataS, d: dataOut, ei: TxElecIdle, en: enb, lu: link_up};
            tests++;
            if (expQ.size() == 0) begin
                fails++;
                $display("FAIL slot%0d: unexpected output k=%b ds=%b d=%h, none queued", slotNo, act.k, act.ds, act.d);
            end else begin
                want = expQ.pop_front();
                if (act !== want) begin
                    fails++;
                    $display("FAIL slot%0d: got k=%b ds=%b d=%h ei=%b en=%b lu=%b, expected k=%b ds=%b d=%h ei=%b en=%b lu=%b",
                             slotNo, act.k, act.ds, act.d, act.ei, act.en, act.lu,
                             want.k, want.ds, want.d, want.ei, want.en, want.lu);
                end
            end
            slotNo++;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        expQ.push_back(cur);
        @(negedge clk);
    endtask

    task automatic sym(input logic [7:0] s);
        cur.k = 1'b1; cur.ds = 2'b00; cur.d = {24'h0, s};
    endtask

    task automatic word(input logic [1:0] ds, input logic [31:0] d);
        cur.k = 1'b0; cur.ds = ds; cur.d = d;
    endtask

    task automatic offVals();
        cur = '{k: 1'b0, ds: 2'b00, d: 32'h0, ei: 1'b1, en: 1'b0, lu: 1'b0};
    endtask

    task automatic burst(input logic [1:0] ds, input logic [31:0] d, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            word(ds, d);
            tick();
        end
    endtask

    task automatic bringUp();
        link_en = 1'b1;
        cur.ei = 1'b0; cur.en = 1'b1;
        tick();
        for (int unsigned i = 0; i < TS; i++) begin
            sym(COM);
            cur.lu = (i == TS - 1);
            tick();
        end
    endtask

    task automatic resetDut();
        monEn = 1'b0;
        rst = 1'b0; link_en = 1'b0; req = 3'b000; idle_req = 1'b0; tx_rdy = 1'b1;
        #1;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_data", dataOut, 32'h0);
        chk("rst_ctl", 32'({K, dataS, TxElecIdle, enb, link_up}), 32'b000100);
        @(negedge clk);
        rst = 1'b1;
        offVals();
        monEn = 1'b1;
    endtask

    initial begin
        rst = 1'b1; link_en = 1'b0; idle_req = 1'b0; tx_rdy = 1'b1; req = 3'b000;
        data8 = 8'h25; data16 = 16'hABCD; data32 = 32'h0123456F;
        offVals();
        @(negedge clk);

        // T1: training
        resetDut();
        bringUp();
        sym(PAD); tick(); tick();

        // T2: single 8-bit source, then SKP after second burst, then req drop
        req = 3'b001;
        sym(PAD); tick(); chk("t2_gnt", 32'(gnt), 32'h1);
        burst(2'b00, 32'h25, 4); chk("t2_release", 32'(gnt), 32'h0);
        sym(PAD); tick();
        burst(2'b00, 32'h25, 4);
        sym(SKP); tick(); chk("t2_skp_nogrant", 32'(gnt), 32'h0);
        sym(PAD); tick(); chk("t2_regrant", 32'(gnt), 32'h1);
        req = 3'b000;
        sym(PAD); tick(); chk("t2_drop", 32'(gnt), 32'h0);

        // T3: all three requesting
        resetDut();
        bringUp();
        req = 3'b111;
        sym(PAD); tick(); chk("t3_gnt0", 32'(gnt), 32'h1);
        burst(2'b00, 32'h25, 4);
        sym(PAD); tick(); chk("t3_gnt1", 32'(gnt), 32'h2);
        burst(2'b01, 32'h0000ABCD, 4);
        sym(SKP); tick();
        sym(PAD); tick(); chk("t3_gnt2", 32'(gnt), 32'h4);
        burst(2'b10, 32'h0123456F, 4);
        sym(PAD); tick(); chk("t3_gnt0b", 32'(gnt), 32'h1);
        burst(2'b00, 32'h25, 4);
        sym(SKP); tick();

        // T5: idle request mid-burst with gapped slots
        req = 3'b001;
        sym(PAD); tick(); chk("t5_gnt", 32'(gnt), 32'h1);
        burst(2'b00, 32'h25, 2);
        idle_req = 1'b1; data8 = 8'h5A; tx_rdy = 1'b0;
        tick(); chk("t5_hold_gnt", 32'(gnt), 32'h1);
        tx_rdy = 1'b1; word(2'b00, 32'h5A); tick();
        tx_rdy = 1'b0; data8 = 8'h66; tick();
        tx_rdy = 1'b1; word(2'b00, 32'h66); tick();
        chk("t5_burst_done", 32'(gnt), 32'h0);
        sym(EIOS); cur.lu = 1'b0; tick();
        tx_rdy = 1'b0; tick();
        tx_rdy = 1'b1; idle_req = 1'b0; offVals(); tick();
        link_en = 1'b0; tick();

        // T6: abort during TRAIN, abort during ACTIVE, reset mid-burst
        link_en = 1'b1; cur.ei = 1'b0; cur.en = 1'b1; tick();
        sym(COM); tick(); tick(); tick();
        link_en = 1'b0; tx_rdy = 1'b0; offVals(); tick(); tick();
        tx_rdy = 1'b1;
        bringUp();
        req = 3'b001;
        sym(PAD); tick(); chk("t6_gnt0", 32'(gnt), 32'h1);
        burst(2'b00, 32'h66, 2);
        link_en = 1'b0; offVals(); tick();
        chk("t6_abort_gnt", 32'(gnt), 32'h0);
        bringUp();
        req = 3'b101;
        sym(PAD); tick(); chk("t6_rr_kept", 32'(gnt), 32'h4);
        burst(2'b10, 32'h0123456F, 2);
        monEn = 1'b0;
        rst = 1'b0;
        #1;
        chk("t6_rst_gnt", 32'(gnt), 32'h0);
        chk("t6_rst_data", dataOut, 32'h0);
        chk("t6_rst_ctl", 32'({K, dataS, TxElecIdle, enb, link_up}), 32'b000100);
        chk("queue_empty", 32'(expQ.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
